// File: rtl/mac_axil_bridge_if.sv
// AXI4-Lite host port plus MMR register-bus port of the mac bridge.
// slave = bridge view, master = host/register-block environment view.
interface mac_axil_bridge_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
);
  logic [ADDR_BITS-1:0]   s_awaddr;
  logic                   s_awvalid, s_awready;
  logic [DATA_BITS-1:0]   s_wdata;
  logic [DATA_BITS/8-1:0] s_wstrb;
  logic                   s_wvalid, s_wready;
  logic [1:0]             s_bresp;
  logic                   s_bvalid, s_bready;
  logic [ADDR_BITS-1:0]   s_araddr;
  logic                   s_arvalid, s_arready;
  logic [DATA_BITS-1:0]   s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rvalid, s_rready;
  logic [ADDR_BITS-1:0]   mmr_addr;
  logic                   mmr_ren, mmr_wen;
  logic [DATA_BITS-1:0]   mmr_wdata;
  logic [DATA_BITS-1:0]   mmr_rdata;
  logic                   mmr_waddr_error, mmr_raddr_error;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready, mmr_rdata, mmr_waddr_error, mmr_raddr_error,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
           mmr_addr, mmr_ren, mmr_wen, mmr_wdata
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready, mmr_rdata, mmr_waddr_error, mmr_raddr_error,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
           mmr_addr, mmr_ren, mmr_wen, mmr_wdata
  );
endinterface

// File: rtl/mac_axil_bridge.sv
// AXI4-Lite slave serialising host reads/writes onto the mac MMR bus.
// One outstanding read and write; MMR error flags become SLVERR.
module mac_axil_bridge #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  mac_axil_bridge_if.slave bus
);
  localparam int STRB_BITS = DATA_BITS / 8;

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_WAIT, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP
  } state_t;
  typedef enum logic {SRV_READ, SRV_WRITE} served_t;

  state_t                 state;
  served_t                last_served;
  logic                   aw_held, w_held, ar_held;
  logic [ADDR_BITS-1:0]   awaddr_h, araddr_h, mmr_addr_r;
  logic [DATA_BITS-1:0]   wdata_h, mmr_wdata_r, rdata_r;
  logic [STRB_BITS-1:0]   wstrb_h;
  logic [1:0]             bresp_r, rresp_r;
  logic                   wr_rdy, rd_rdy, wstrb_full;

  assign wr_rdy     = aw_held & w_held;
  assign rd_rdy     = ar_held;
  assign wstrb_full = &wstrb_h;

  assign bus.s_awready = !aw_held;
  assign bus.s_wready  = !w_held;
  assign bus.s_arready = !ar_held;
  assign bus.s_bvalid  = (state == WR_RESP);
  assign bus.s_rvalid  = (state == RD_RESP);
  assign bus.s_bresp   = bresp_r;
  assign bus.s_rresp   = rresp_r;
  assign bus.s_rdata   = rdata_r;
  assign bus.mmr_addr  = mmr_addr_r;
  assign bus.mmr_wdata = mmr_wdata_r;
  // Partial strobes are never written: the MMR bus has no byte enables.
  assign bus.mmr_wen   = (state == WR_ISSUE) && wstrb_full;
  assign bus.mmr_ren   = (state == RD_ISSUE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      last_served <= SRV_READ;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      ar_held     <= 1'b0;
      awaddr_h    <= '0;
      araddr_h    <= '0;
      wdata_h     <= '0;
      wstrb_h     <= '0;
      mmr_addr_r  <= '0;
      mmr_wdata_r <= '0;
      rdata_r     <= '0;
      bresp_r     <= 2'b00;
      rresp_r     <= 2'b00;
    end else begin
      if (bus.s_awvalid && !aw_held) begin
        awaddr_h <= bus.s_awaddr;
        aw_held  <= 1'b1;
      end
      if (bus.s_wvalid && !w_held) begin
        wdata_h <= bus.s_wdata;
        wstrb_h <= bus.s_wstrb;
        w_held  <= 1'b1;
      end
      if (bus.s_arvalid && !ar_held) begin
        araddr_h <= bus.s_araddr;
        ar_held  <= 1'b1;
      end

      case (state)
        IDLE: begin
          // On a tie, serve whichever type did not go last.
          if (wr_rdy && (!rd_rdy || last_served == SRV_READ)) begin
            state       <= WR_ISSUE;
            mmr_addr_r  <= awaddr_h;
            mmr_wdata_r <= wdata_h;
          end else if (rd_rdy) begin
            state      <= RD_ISSUE;
            mmr_addr_r <= araddr_h;
          end
        end
        WR_ISSUE: state <= WR_WAIT;
        WR_WAIT: begin
          bresp_r <= (bus.mmr_waddr_error || !wstrb_full) ? 2'b10 : 2'b00;
          state   <= WR_RESP;
        end
        WR_RESP: if (bus.s_bready) begin
          aw_held     <= 1'b0;
          w_held      <= 1'b0;
          last_served <= SRV_WRITE;
          state       <= IDLE;
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          rdata_r <= bus.mmr_rdata;
          rresp_r <= bus.mmr_raddr_error ? 2'b10 : 2'b00;
          state   <= RD_RESP;
        end
        RD_RESP: if (bus.s_rready) begin
          ar_held     <= 1'b0;
          last_served <= SRV_READ;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_axil_bridge.sv
// Directed + random bench for mac_axil_bridge with an MMR register-block model
// and an address-map reference predicting every AXI response.
module tb_mac_axil_bridge;
  localparam int AB = 12;
  localparam int DB = 32;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  mac_axil_bridge_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
  mac_axil_bridge #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  int total = 0, passed = 0, failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register map: 16 words at 0x00..0x3C, 0x0C read-only; misaligned or >=0x40 errors.
  function automatic bit addr_ok(input logic [AB-1:0] a);
    return (a[1:0] == 2'b00) && (a < 12'h040);
  endfunction
  function automatic bit addr_wr(input logic [AB-1:0] a);
    return addr_ok(a) && (a != 12'h00C);
  endfunction

  // MMR register block: registers responses one cycle after each pulse.
  logic [DB-1:0] mmr_mem [16];
  int            wen_cnt = 0, ren_cnt = 0, both_cnt = 0;
  logic [AB-1:0] last_wen_addr;
  logic [DB-1:0] last_wen_data;
  bit            pulse_log [$];

  always @(posedge clk) begin
    bus.mmr_waddr_error <= 1'b0;
    bus.mmr_raddr_error <= 1'b0;
    if (bus.mmr_wen && bus.mmr_ren) both_cnt++;
    if (bus.mmr_wen) begin
      wen_cnt++;
      last_wen_addr = bus.mmr_addr;
      last_wen_data = bus.mmr_wdata;
      pulse_log.push_back(1'b1);
      if (addr_wr(bus.mmr_addr)) mmr_mem[bus.mmr_addr[5:2]] = bus.mmr_wdata;
      else bus.mmr_waddr_error <= 1'b1;
    end
    if (bus.mmr_ren) begin
      ren_cnt++;
      pulse_log.push_back(1'b0);
      bus.mmr_rdata       <= addr_ok(bus.mmr_addr) ? mmr_mem[bus.mmr_addr[5:2]] : '0;
      bus.mmr_raddr_error <= !addr_ok(bus.mmr_addr);
    end
  end

  // Reference: what the host should see.
  logic [DB-1:0] ref_mem [16];

  function automatic logic [1:0] ref_write(input logic [AB-1:0] a, input logic [DB-1:0] d,
                                           input logic [3:0] s);
    if (s != 4'hF || !addr_wr(a)) return 2'b10;
    ref_mem[a[5:2]] = d;
    return 2'b00;
  endfunction

  task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [3:0] s,
                          input int aw_dly, input int bp, output logic [1:0] resp, output int lat);
    bit aw_acc, w_acc, stable;
    logic [1:0] r0;
    int n;
    resp = 2'bxx; lat = -1;
    bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = s;
    bus.s_wvalid = 1'b1; bus.s_awvalid = 1'b0;
    for (n = 0; n < 60; n++) begin
      if (n == aw_dly) bus.s_awvalid = 1'b1;
      aw_acc = bus.s_awvalid && bus.s_awready;
      w_acc  = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1;
      if (aw_acc) bus.s_awvalid = 1'b0;
      if (w_acc) bus.s_wvalid = 1'b0;
      if (n >= aw_dly && !bus.s_awvalid && !bus.s_wvalid) break;
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    for (n = 0; n < 40 && !bus.s_bvalid; n++) begin @(posedge clk); #1; end
    if (!bus.s_bvalid) begin chk("bvalid_timeout", 64'(bus.s_bvalid), 64'd1); return; end
    lat = n; r0 = bus.s_bresp; stable = 1'b1;
    repeat (bp) begin
      @(posedge clk); #1;
      if (!bus.s_bvalid || bus.s_bresp !== r0) stable = 1'b0;
    end
    if (bp > 0) chk("bresp_stable", 64'(stable), 64'd1);
    resp = bus.s_bresp;
    bus.s_bready = 1'b1;
    @(posedge clk); #1;
    bus.s_bready = 1'b0;
    chk("bvalid_drop", 64'(bus.s_bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [AB-1:0] a, input int bp,
                         output logic [DB-1:0] d, output logic [1:0] resp, output int lat);
    bit stable;
    logic [DB-1:0] d0;
    int n;
    d = 'x; resp = 2'bxx; lat = -1;
    bus.s_araddr = a; bus.s_arvalid = 1'b1;
    for (n = 0; n < 40 && !bus.s_arready; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    for (n = 0; n < 40 && !bus.s_rvalid; n++) begin @(posedge clk); #1; end
    if (!bus.s_rvalid) begin chk("rvalid_timeout", 64'(bus.s_rvalid), 64'd1); return; end
    lat = n; d0 = bus.s_rdata; stable = 1'b1;
    repeat (bp) begin
      @(posedge clk); #1;
      if (!bus.s_rvalid || bus.s_rdata !== d0) stable = 1'b0;
    end
    if (bp > 0) chk("rdata_stable", 64'(stable), 64'd1);
    d = bus.s_rdata; resp = bus.s_rresp;
    bus.s_rready = 1'b1;
    @(posedge clk); #1;
    bus.s_rready = 1'b0;
    chk("rvalid_drop", 64'(bus.s_rvalid), 64'd0);
  endtask

  task automatic wr_chk(input string tag, input logic [AB-1:0] a, input logic [DB-1:0] d,
                        input logic [3:0] s, input int aw_dly, input int bp);
    logic [1:0] exp, resp;
    int lat, w0;
    w0 = wen_cnt;
    exp = ref_write(a, d, s);
    do_write(a, d, s, aw_dly, bp, resp, lat);
    chk({tag, "_bresp"}, 64'(resp), 64'(exp));
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_wen_count"}, 64'(wen_cnt - w0), (s == 4'hF) ? 64'd1 : 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [AB-1:0] a, input int bp);
    logic [DB-1:0] d;
    logic [1:0] resp;
    int lat;
    do_read(a, bp, d, resp, lat);
    chk({tag, "_rdata"}, 64'(d), addr_ok(a) ? 64'(ref_mem[a[5:2]]) : 64'd0);
    chk({tag, "_rresp"}, 64'(resp), addr_ok(a) ? 64'd0 : 64'd2);
    chk({tag, "_lat"}, 64'(lat), 64'd3);
  endtask

  // AW+W and AR offered in the same cycle; reports which pulse reached the MMR bus first.
  task automatic do_both(input string tag, input logic [AB-1:0] wa, input logic [DB-1:0] wd,
                         input logic [AB-1:0] ra, input bit exp_write_first);
    bit got_b, got_r;
    logic [1:0] bresp, rresp, exp_b;
    logic [DB-1:0] rdata;
    pulse_log.delete();
    exp_b = ref_write(wa, wd, 4'hF);
    bus.s_awaddr = wa; bus.s_wdata = wd; bus.s_wstrb = 4'hF; bus.s_araddr = ra;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    got_b = 1'b0; got_r = 1'b0; bresp = 2'bxx; rresp = 2'bxx; rdata = 'x;
    for (int n = 0; n < 40 && !(got_b && got_r); n++) begin
      if (bus.s_bvalid) begin got_b = 1'b1; bresp = bus.s_bresp; end
      if (bus.s_rvalid) begin got_r = 1'b1; rresp = bus.s_rresp; rdata = bus.s_rdata; end
      @(posedge clk); #1;
    end
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    chk({tag, "_both_done"}, 64'(got_b && got_r), 64'd1);
    chk({tag, "_pulses"}, 64'(pulse_log.size()), 64'd2);
    chk({tag, "_write_first"}, (pulse_log.size() > 0) ? 64'(pulse_log[0]) : 64'd2,
        64'(exp_write_first));
    chk({tag, "_bresp"}, 64'(bresp), 64'(exp_b));
    chk({tag, "_rresp"}, 64'(rresp), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'(ref_mem[ra[5:2]]));
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen_b;
    logic [AB-1:0] a;
    logic [3:0] s;

    for (int i = 0; i < 16; i++) begin mmr_mem[i] = '0; ref_mem[i] = '0; end
    mmr_mem[3] = 32'h1234_5678; ref_mem[3] = 32'h1234_5678;
    arst_n = 1'b0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(bus.s_awready), 64'd1);
    chk("rst_wready", 64'(bus.s_wready), 64'd1);
    chk("rst_arready", 64'(bus.s_arready), 64'd1);
    chk("rst_bvalid", 64'(bus.s_bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.s_rvalid), 64'd0);
    chk("rst_pulses", 64'({bus.mmr_wen, bus.mmr_ren}), 64'd0);
    chk("rst_mmr_addr", 64'(bus.mmr_addr), 64'd0);
    chk("rst_rdata", 64'(bus.s_rdata), 64'd0);
    chk("rst_resp", 64'({bus.s_bresp, bus.s_rresp}), 64'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    wr_chk("w0", 12'h000, 32'h3F80_0000, 4'hF, 0, 0);
    chk("w0_mmr_addr", 64'(last_wen_addr), 64'h0);
    chk("w0_mmr_wdata", 64'(last_wen_data), 64'h3F80_0000);
    rd_chk("r0", 12'h000, 0);

    wr_chk("w_first", 12'h008, 32'hCAFE_0008, 4'hF, 3, 0);
    chk("w_first_addr", 64'(last_wen_addr), 64'h8);
    rd_chk("r_c", 12'h00C, 0);

    wr_chk("w_ro", 12'h00C, 32'hDEAD_BEEF, 4'hF, 0, 0);
    wr_chk("w_oor", 12'h040, 32'hDEAD_BEEF, 4'hF, 1, 0);
    rd_chk("r_oor", 12'h040, 0);
    wr_chk("w_part", 12'h000, 32'h1111_1111, 4'h3, 0, 0);
    rd_chk("r_part", 12'h000, 0);

    pulse_reset();
    do_both("tie1", 12'h010, 32'hA5A5_0010, 12'h014, 1'b1);
    do_both("tie2", 12'h014, 32'hA5A5_0014, 12'h010, 1'b1);
    wr_chk("w_lone", 12'h01C, 32'h0000_001C, 4'hF, 0, 0);
    do_both("tie3", 12'h010, 32'h5A5A_0010, 12'h01C, 1'b0);

    wr_chk("w_bp", 12'h018, 32'h600D_F00D, 4'hF, 0, 5);
    rd_chk("r_bp", 12'h018, 5);

    // Reset lands while the write is in WR_WAIT.
    bus.s_awaddr = 12'h004; bus.s_wdata = 32'hFFFF_FFFF; bus.s_wstrb = 4'h3;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    arst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", 64'(bus.s_bvalid), 64'd0);
    chk("mid_rst_ready", 64'({bus.s_awready, bus.s_wready}), 64'd3);
    chk("mid_rst_mmr", 64'({bus.mmr_addr, bus.mmr_wdata}), 64'd0);
    chk("mid_rst_pulses", 64'({bus.mmr_wen, bus.mmr_ren}), 64'd0);
    @(posedge clk); #1 arst_n = 1'b1;
    seen_b = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (bus.s_bvalid) seen_b = 1'b1; end
    chk("mid_rst_no_bvalid", 64'(seen_b), 64'd0);

    for (int t = 0; t < 40; t++) begin
      a = AB'($urandom_range(0, 17) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 12'h2;
      if ($urandom_range(0, 1) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        wr_chk("rnd_w", a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        rd_chk("rnd_r", a, $urandom_range(0, 2));
      end
    end

    chk("never_both_pulses", 64'(both_cnt), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
